// File: rtl/phy_clk_div_gen_if.sv
// ============================================================================
// Module   : phy_clk_div_gen_if
// Brief    : Width select and derived-clock outputs of the PHY clock divider.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface phy_clk_div_gen_if;
    logic [5:0] DataBusWidth;
    logic       Word_CLK;
    logic       PCLK;
    logic       Word_Strobe;
    logic       Clk_Locked;
    logic       Width_Err;

    modport master (
        output DataBusWidth,
        input  Word_CLK, PCLK, Word_Strobe, Clk_Locked, Width_Err
    );

    modport slave (
        input  DataBusWidth,
        output Word_CLK, PCLK, Word_Strobe, Clk_Locked, Width_Err
    );
endinterface

`default_nettype wire

// File: rtl/phy_clk_div_gen.sv
// ============================================================================
// Module   : phy_clk_div_gen
// Brief    : Derives Word_CLK, PCLK and the word load strobe from Bit_CLK,
//            with a glitch-free PCLK ratio switch at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module phy_clk_div_gen #(
    parameter int WORD_BITS     = 10,
    parameter int DEFAULT_WIDTH = 8
) (
    input  wire logic          Bit_CLK,
    input  wire logic          Rst,
    phy_clk_div_gen_if.slave   phy_if
);

    localparam int c_BW = $clog2(WORD_BITS);
    localparam int c_PW = $clog2(4 * WORD_BITS) + 1;

    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WORD_BITS - 1);
    localparam logic [c_BW-1:0] c_BIT_HALF = c_BW'(WORD_BITS / 2);
    localparam logic [c_PW-1:0] c_WB_P     = c_PW'(WORD_BITS);
    localparam logic [c_PW-1:0] c_HALF_P   = c_PW'(WORD_BITS / 2);

    // Ratio is carried as N itself (1, 2 or 4); 0 marks an illegal width.
    function automatic logic [2:0] f_decode(input logic [5:0] width);
        case (width)
            6'd8:    return 3'd1;
            6'd16:   return 3'd2;
            6'd32:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    localparam logic [2:0] c_N_DEF = f_decode(6'(DEFAULT_WIDTH));

    logic [c_BW-1:0] bit_cnt_q,  bit_cnt_d;
    logic [1:0]      word_cnt_q, word_cnt_d;
    logic [2:0]      n_act_q,    n_act_d;
    logic [2:0]      n_pend_q,   n_pend_d;
    logic            seen_q,     seen_d;
    logic            word_clk_q, word_clk_d;
    logic            pclk_q,     pclk_d;
    logic            strobe_q,   strobe_d;
    logic            locked_q,   locked_d;
    logic            werr_q,     werr_d;

    logic [2:0]      w_n_dec;
    logic            w_legal;
    logic            w_mismatch;
    logic            w_bit_last;
    logic            w_boundary;
    logic            w_rise;
    logic [1:0]      w_word_last;
    logic [c_PW-1:0] w_phase;
    logic [c_PW-1:0] w_pclk_half;

    always_comb begin
        w_n_dec     = f_decode(phy_if.DataBusWidth);
        w_legal     = |w_n_dec;
        n_pend_d    = w_legal ? w_n_dec : n_pend_q;
        w_mismatch  = (n_pend_d != n_act_q);
        w_word_last = 2'(n_act_q - 3'd1);
        w_bit_last  = (bit_cnt_q == c_BIT_LAST);
        w_boundary  = w_bit_last && (word_cnt_q == w_word_last);
        w_phase     = (c_PW'(word_cnt_q) * c_WB_P) + c_PW'(bit_cnt_q);
        w_rise      = (w_phase == '0);

        case (n_act_q)
            3'd2:    w_pclk_half = c_WB_P;
            3'd4:    w_pclk_half = c_WB_P << 1;
            default: w_pclk_half = c_HALF_P;
        endcase

        bit_cnt_d  = w_bit_last ? '0 : bit_cnt_q + 1'b1;
        word_cnt_d = word_cnt_q;
        n_act_d    = n_act_q;
        seen_d     = seen_q | w_rise;

        // Ratio changes only at the PCLK period end, so the next period starts high.
        if (w_bit_last) begin
            if (w_boundary) begin
                word_cnt_d = '0;
                if (w_mismatch) begin
                    n_act_d = n_pend_d;
                    seen_d  = 1'b0;
                end
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        word_clk_d = (bit_cnt_q < c_BIT_HALF);
        pclk_d     = (w_phase < w_pclk_half);
        strobe_d   = w_bit_last;
        werr_d     = !w_legal;

        locked_d = locked_q;
        if (w_mismatch) begin
            locked_d = 1'b0;
        end else if (w_rise && seen_q) begin
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge Bit_CLK or posedge Rst) begin
        if (Rst) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            n_act_q    <= c_N_DEF;
            n_pend_q   <= c_N_DEF;
            seen_q     <= 1'b0;
            word_clk_q <= 1'b0;
            pclk_q     <= 1'b0;
            strobe_q   <= 1'b0;
            locked_q   <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            n_act_q    <= n_act_d;
            n_pend_q   <= n_pend_d;
            seen_q     <= seen_d;
            word_clk_q <= word_clk_d;
            pclk_q     <= pclk_d;
            strobe_q   <= strobe_d;
            locked_q   <= locked_d;
            werr_q     <= werr_d;
        end
    end

    assign phy_if.Word_CLK    = word_clk_q;
    assign phy_if.PCLK        = pclk_q;
    assign phy_if.Word_Strobe = strobe_q;
    assign phy_if.Clk_Locked  = locked_q;
    assign phy_if.Width_Err   = werr_q;

endmodule

`default_nettype wire
